// File: rtl/dte_ebus_port.sv
// dte_ebus_port: front-end (DTE20) port onto the KL10 EBUS.
// Runs console diagnostic reads/writes against EBOX modules and answers
// EBOX CONO/CONI cycles addressed to device code DEV_CS.
//
// Handshakes: a host command transfers on the rising edge where
// host_cmd_valid && host_cmd_ready; host_rsp_valid is a one-cycle pulse
// with no back-pressure; an EBOX cycle completes in the single cycle that
// ebox_ack is high (the EBOX drops ebox_req after seeing it).
module dte_ebus_port #(
    parameter logic [6:0] DEV_CS = 7'b0100000,
    parameter int         SETTLE = 2          // must be >= 1
) (
    input  logic        clk,
    input  logic        CROBAR,
    input  logic        host_cmd_valid,
    output logic        host_cmd_ready,
    input  logic [1:0]  host_cmd_op,
    input  logic [6:0]  host_cmd_func,
    input  logic [0:35] host_cmd_data,
    output logic        host_rsp_valid,
    output logic [0:35] host_rsp_data,
    input  logic [0:35] ebus_data_in,
    output logic        ebus_driving,
    output logic [0:35] ebus_data_out,
    output logic [6:0]  ebus_diag_func,
    output logic        ebus_diag_active,
    output logic        ebus_diag_strobe,
    input  logic        ebox_req,
    input  logic [6:0]  ebox_cs,
    input  logic [2:0]  ebox_func,
    output logic        ebox_ack,
    output logic [0:35] status,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_HOLD = 3'd2,
        S_RD      = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);

    localparam logic [2:0] F_CONO = 3'd0;
    localparam logic [2:0] F_CONI = 3'd1;

    state_t         state_q, state_d;
    logic [6:0]     func_q, func_d;
    logic [0:35]    wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [0:35]    status_q, status_d;
    logic [0:35]    rsp_data_q, rsp_data_d;
    logic           ebox_hit;

    // An EBOX cycle is served only from IDLE and only for our CONO/CONI.
    assign ebox_hit = (state_q == S_IDLE) && !CROBAR && ebox_req &&
                      (ebox_cs == DEV_CS) &&
                      ((ebox_func == F_CONO) || (ebox_func == F_CONI));

    assign status        = status_q;
    assign host_rsp_data = rsp_data_q;
    assign dbg_state_o   = state_q;

    // State and datapath registers; CROBAR clears everything at once.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state_q    <= S_IDLE;
            func_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            status_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state and outputs; EBOX service takes priority over host commands.
    always_comb begin
        state_d          = state_q;
        func_d           = func_q;
        wdata_d          = wdata_q;
        cnt_d            = cnt_q;
        status_d         = status_q;
        rsp_data_d       = rsp_data_q;
        host_cmd_ready   = 1'b0;
        host_rsp_valid   = 1'b0;
        ebus_driving     = 1'b0;
        ebus_data_out    = '0;
        ebus_diag_func   = '0;
        ebus_diag_active = 1'b0;
        ebus_diag_strobe = 1'b0;
        ebox_ack         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ebox_hit) begin
                    ebox_ack = 1'b1;
                    if (ebox_func == F_CONI) begin
                        ebus_driving  = 1'b1;
                        ebus_data_out = status_q;
                    end else begin
                        status_d = ebus_data_in;
                    end
                end else if (!CROBAR) begin
                    host_cmd_ready = 1'b1;
                    if (host_cmd_valid) begin
                        case (host_cmd_op)
                            2'd0: begin
                                func_d  = host_cmd_func;
                                cnt_d   = '0;
                                state_d = S_RD;
                            end
                            2'd1: begin
                                func_d  = host_cmd_func;
                                wdata_d = host_cmd_data;
                                state_d = S_WR;
                            end
                            2'd2:    status_d = status_q | host_cmd_data;
                            default: status_d = status_q & ~host_cmd_data;
                        endcase
                    end
                end
            end
            S_WR: begin
                ebus_diag_active = 1'b1;
                ebus_diag_func   = func_q;
                ebus_driving     = 1'b1;
                ebus_data_out    = wdata_q;
                ebus_diag_strobe = 1'b1;
                state_d          = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                ebus_diag_active = 1'b1;
                ebus_diag_func   = func_q;
                ebus_driving     = 1'b1;
                ebus_data_out    = wdata_q;
                state_d          = S_IDLE;
            end
            S_RD: begin
                ebus_diag_active = 1'b1;
                ebus_diag_func   = func_q;
                // The addressed module needs SETTLE cycles before its data is valid.
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = ebus_data_in;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                host_rsp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dte_ebus_port.sv
// tb_dte_ebus_port: directed plus randomized checks of dte_ebus_port
// against a small behavioural model (status word, last read response).
module tb_dte_ebus_port;

    localparam logic [6:0] DEV_CS = 7'b0100000;
    localparam int         SETTLE = 2;

    logic        clk;
    logic        CROBAR;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic [1:0]  host_cmd_op;
    logic [6:0]  host_cmd_func;
    logic [0:35] host_cmd_data;
    logic        host_rsp_valid;
    logic [0:35] host_rsp_data;
    logic [0:35] ebus_data_in;
    logic        ebus_driving;
    logic [0:35] ebus_data_out;
    logic [6:0]  ebus_diag_func;
    logic        ebus_diag_active;
    logic        ebus_diag_strobe;
    logic        ebox_req;
    logic [6:0]  ebox_cs;
    logic [2:0]  ebox_func;
    logic        ebox_ack;
    logic [0:35] status;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [35:0] m_status;
    logic [35:0] m_rsp;

    dte_ebus_port #(.DEV_CS(DEV_CS), .SETTLE(SETTLE)) dut (
        .clk(clk), .CROBAR(CROBAR),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_cmd_func(host_cmd_func),
        .host_cmd_data(host_cmd_data),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
        .ebus_data_in(ebus_data_in), .ebus_driving(ebus_driving),
        .ebus_data_out(ebus_data_out), .ebus_diag_func(ebus_diag_func),
        .ebus_diag_active(ebus_diag_active), .ebus_diag_strobe(ebus_diag_strobe),
        .ebox_req(ebox_req), .ebox_cs(ebox_cs), .ebox_func(ebox_func),
        .ebox_ack(ebox_ack), .status(status), .dbg_state_o(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] rnd36();
        return {$urandom_range(0, 15), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge (drive point).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".driving"}, 36'(ebus_driving), 36'd0);
        check({tag, ".data_out"}, ebus_data_out, 36'd0);
        check({tag, ".active"}, 36'(ebus_diag_active), 36'd0);
        check({tag, ".func"}, 36'(ebus_diag_func), 36'd0);
        check({tag, ".strobe"}, 36'(ebus_diag_strobe), 36'd0);
        check({tag, ".ack"}, 36'(ebox_ack), 36'd0);
    endtask

    task automatic do_write(input logic [6:0] f, input logic [35:0] d);
        host_cmd_valid = 1'b1; host_cmd_op = 2'd1; host_cmd_func = f; host_cmd_data = d;
        #1 check("wr.ready", 36'(host_cmd_ready), 36'd1);
        tick();
        host_cmd_valid = 1'b0; host_cmd_data = rnd36(); host_cmd_func = 7'(~f);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("wr.active", 36'(ebus_diag_active), 36'd1);
            check("wr.func", 36'(ebus_diag_func), 36'(f));
            check("wr.driving", 36'(ebus_driving), 36'd1);
            check("wr.data_out", ebus_data_out, d);
            check("wr.strobe", 36'(ebus_diag_strobe), (c == 0) ? 36'd1 : 36'd0);
            check("wr.ready_busy", 36'(host_cmd_ready), 36'd0);
            check("wr.rsp_valid", 36'(host_rsp_valid), 36'd0);
            tick();
        end
        #1;
        check_quiet("wr.after");
        check("wr.after.ready", 36'(host_cmd_ready), 36'd1);
    endtask

    task automatic do_read(input logic [6:0] f, input logic [35:0] din);
        host_cmd_valid = 1'b1; host_cmd_op = 2'd0; host_cmd_func = f; ebus_data_in = rnd36();
        #1 check("rd.ready", 36'(host_cmd_ready), 36'd1);
        tick();
        host_cmd_valid = 1'b0;
        // Cycles 1..SETTLE after accept: bus settling; only the last sample counts.
        for (int c = 1; c <= SETTLE; c++) begin
            ebus_data_in = (c == SETTLE) ? din : rnd36();
            #1;
            check("rd.active", 36'(ebus_diag_active), 36'd1);
            check("rd.func", 36'(ebus_diag_func), 36'(f));
            check("rd.driving", 36'(ebus_driving), 36'd0);
            check("rd.rsp_early", 36'(host_rsp_valid), 36'd0);
            tick();
        end
        ebus_data_in = rnd36();
        m_rsp = din;
        #1;
        check("rd.rsp_valid", 36'(host_rsp_valid), 36'd1);
        check("rd.rsp_data", host_rsp_data, m_rsp);
        check("rd.resp_driving", 36'(ebus_driving), 36'd0);
        tick();
        #1;
        check("rd.rsp_pulse", 36'(host_rsp_valid), 36'd0);
        check("rd.rsp_hold", host_rsp_data, m_rsp);
        check("rd.ready_after", 36'(host_cmd_ready), 36'd1);
    endtask

    task automatic do_status(input logic [1:0] op, input logic [35:0] mask);
        host_cmd_valid = 1'b1; host_cmd_op = op; host_cmd_data = mask;
        #1 check("st.ready", 36'(host_cmd_ready), 36'd1);
        tick();
        host_cmd_valid = 1'b0;
        if (op == 2'd2) m_status = m_status | mask;
        else            m_status = m_status & ~mask;
        #1;
        check("st.status", status, m_status);
        check("st.no_rsp", 36'(host_rsp_valid), 36'd0);
        check("st.ready_after", 36'(host_cmd_ready), 36'd1);
    endtask

    // One EBOX request cycle, optionally colliding with a host op2 command.
    task automatic do_ebox(input logic [2:0] f, input logic [6:0] cs,
                           input logic [35:0] din, input bit collide,
                           input logic [35:0] mask);
        bit hit;
        bit coni;
        hit  = (cs == DEV_CS) && (f == 3'd0 || f == 3'd1);
        coni = hit && (f == 3'd1);
        ebox_req = 1'b1; ebox_cs = cs; ebox_func = f; ebus_data_in = din;
        if (collide) begin
            host_cmd_valid = 1'b1; host_cmd_op = 2'd2; host_cmd_data = mask;
        end
        #1;
        check("eb.ack", 36'(ebox_ack), 36'(hit));
        check("eb.driving", 36'(ebus_driving), 36'(coni));
        check("eb.data_out", ebus_data_out, coni ? m_status : 36'd0);
        check("eb.ready", 36'(host_cmd_ready), hit ? 36'd0 : 36'd1);
        tick();
        ebox_req = 1'b0;
        if (hit && f == 3'd0) m_status = din;
        if (collide && !hit) m_status = m_status | mask;
        #1;
        check("eb.status", status, m_status);
        check("eb.ack_off", 36'(ebox_ack), 36'd0);
        if (collide && hit) begin
            check("eb.host_next", 36'(host_cmd_ready), 36'd1);
            tick();
            m_status = m_status | mask;
            #1 check("eb.host_status", status, m_status);
        end
        host_cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset, with a live EBOX hit and host command that must be ignored.
        CROBAR = 1'b1;
        host_cmd_valid = 1'b1; host_cmd_op = 2'd2; host_cmd_func = 7'o005;
        host_cmd_data = 36'o777777777777; ebus_data_in = 36'o123;
        ebox_req = 1'b1; ebox_cs = DEV_CS; ebox_func = 3'd1;
        m_status = '0; m_rsp = '0;
        tick(); tick();
        #1;
        check_quiet("rst");
        check("rst.ready", 36'(host_cmd_ready), 36'd0);
        check("rst.rsp_valid", 36'(host_rsp_valid), 36'd0);
        check("rst.rsp_data", host_rsp_data, 36'd0);
        check("rst.status", status, 36'd0);
        host_cmd_valid = 1'b0; ebox_req = 1'b0;
        CROBAR = 1'b0;
        tick();
        #1;
        check("rel.ready", 36'(host_cmd_ready), 36'd1);
        check_quiet("rel");

        // Directed test plan
        do_write(7'o071, 36'o123456701234);
        do_read(7'o005, 36'o777000111222);
        do_status(2'd2, 36'o000000000017);
        do_status(2'd3, 36'o000000000005);
        check("plan.status12", status, 36'o12);
        do_ebox(3'd1, DEV_CS, rnd36(), 1'b0, '0);                 // CONI
        do_ebox(3'd0, DEV_CS, 36'o400000000001, 1'b0, '0);        // CONO
        do_ebox(3'd0, 7'b0000001, 36'o111111111111, 1'b0, '0);    // wrong cs
        do_ebox(3'd5, DEV_CS, 36'o222222222222, 1'b0, '0);        // bad func
        do_ebox(3'd1, DEV_CS, rnd36(), 1'b1, 36'o000000000700);   // collision

        // EBOX request held across a diag write: acked once back in IDLE.
        host_cmd_valid = 1'b1; host_cmd_op = 2'd1; host_cmd_func = 7'o033;
        host_cmd_data = 36'o555555555555;
        tick();
        host_cmd_valid = 1'b0;
        ebox_req = 1'b1; ebox_cs = DEV_CS; ebox_func = 3'd1;
        #1;
        check("hold.wr_ack", 36'(ebox_ack), 36'd0);
        check("hold.wr_data", ebus_data_out, 36'o555555555555);
        tick();
        #1 check("hold.hold_ack", 36'(ebox_ack), 36'd0);
        tick();
        #1;
        check("hold.idle_ack", 36'(ebox_ack), 36'd1);
        check("hold.idle_data", ebus_data_out, m_status);
        check("hold.idle_ready", 36'(host_cmd_ready), 36'd0);
        tick();
        ebox_req = 1'b0;
        #1 check("hold.ready_back", 36'(host_cmd_ready), 36'd1);

        // CROBAR in the middle of a diag read: response is lost.
        host_cmd_valid = 1'b1; host_cmd_op = 2'd0; host_cmd_func = 7'o044;
        tick();
        host_cmd_valid = 1'b0;
        #1 check("crb.rd_active", 36'(ebus_diag_active), 36'd1);
        CROBAR = 1'b1;
        #1;
        check_quiet("crb");
        check("crb.status", status, 36'd0);
        check("crb.rsp_data", host_rsp_data, 36'd0);
        m_status = '0; m_rsp = '0;
        tick();
        CROBAR = 1'b0;
        #1 check("crb.ready", 36'(host_cmd_ready), 36'd1);
        for (int c = 0; c < SETTLE + 1; c++) begin
            tick();
            #1 check("crb.no_rsp", 36'(host_rsp_valid), 36'd0);
        end

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: do_write(7'($urandom_range(0, 127)), rnd36());
                1: do_read(7'($urandom_range(1, 127)), rnd36());
                2: do_status(2'd2, rnd36());
                3: do_status(2'd3, rnd36());
                4: do_ebox(3'($urandom_range(0, 2)),
                           ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV_CS,
                           rnd36(), 1'b0, '0);
                default: do_ebox(3'($urandom_range(0, 1)), DEV_CS, rnd36(), 1'b1, rnd36());
            endcase
            tick();
        end
        #1 check("final.status", status, m_status);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dte_ebus_port.md
Name: dte_ebus_port

Overview:
- Front-end (DTE20) port onto the KL10 EBUS.
- Executes console-side diagnostic reads and writes (diag function + strobe) against EBOX modules.
- Answers EBOX CONO/CONI I/O cycles addressed to its device code.
- Its EBUS output pair (driving, data) feeds the top-level one-hot EBUS data mux alongside APR, CON, CRA and the other EBOX drivers.

Parameters:
- DEV_CS, 7'b0100000, EBUS controller-select code this DTE answers to (device 200 octal).
- SETTLE, 2, cycles a diagnostic read waits before sampling the EBUS data input (minimum 1).

Ports:
- clk  in  1  master clock; all state changes on rising edge.
- CROBAR  in  1  asynchronous active-high reset (power crowbar).
- host_cmd_valid  in  1  host command offered.
- host_cmd_ready  out  1  high only in IDLE with no EBOX cycle being served.
- host_cmd_op  in  2  0=diag read, 1=diag write, 2=set status bits, 3=clear status bits.
- host_cmd_func  in  7  diagnostic function code for ops 0/1.
- host_cmd_data  in  36  write data (op1) or status mask (op2/3); bit 0 MSB ([0:35]).
- host_rsp_valid  out  1  one-cycle pulse carrying diag-read result.
- host_rsp_data  out  36  read result; held until the next response.
- ebus_data_in  in  36  muxed EBUS data.
- ebus_driving  out  1  this block owns EBUS data.
- ebus_data_out  out  36  value driven when ebus_driving.
- ebus_diag_func  out  7  diagnostic function code; 0 when idle.
- ebus_diag_active  out  1  diag cycle in progress.
- ebus_diag_strobe  out  1  one-cycle write strobe.
- ebox_req  in  1  EBOX I/O cycle request.
- ebox_cs  in  7  controller select.
- ebox_func  in  3  0=CONO, 1=CONI, others ignored.
- ebox_ack  out  1  one-cycle acknowledge.
- status  out  36  internal status register.

Behaviour:
- Reset: all outputs 0, status=0, state IDLE, host_rsp_data=0.
- ebus_data_out is 0 whenever ebus_driving=0.
- States:
  - IDLE: host_cmd_ready=1 unless an EBOX cycle is being served. Accept a command on valid&&ready.
    - op2: status |= data, next cycle.
    - op3: status &= ~data, next cycle.
    - Both return to IDLE with no response.
  - WR (1 cycle, op1): ebus_diag_active=1, ebus_diag_func=func, ebus_driving=1, ebus_data_out=data, ebus_diag_strobe=1 → WR_HOLD.
  - WR_HOLD (1 cycle): same as WR except strobe=0 → IDLE. No response.
  - RD (op0): diag_active=1, func driven, ebus_driving=0. Count SETTLE cycles; on the last one sample ebus_data_in into host_rsp_data → RESP.
  - RESP: host_rsp_valid=1 for one cycle → IDLE.
- Diag read latency: accept edge to host_rsp_valid = SETTLE+1 cycles.
- EBOX I/O: serviced only from IDLE, and only when ebox_req && ebox_cs==DEV_CS.
  - If a host command is valid in the same cycle, the EBOX cycle wins and host_cmd_ready=0.
  - CONI: for one cycle drive ebus_driving=1, ebus_data_out=status, ebox_ack=1.
  - CONO: status <= ebus_data_in, ebox_ack=1 for one cycle; no driving.
  - Unrecognised func, or a cs mismatch: no ack, no drive.
  - A request arriving during a host sequence waits; it is acked in the first IDLE cycle after the sequence, if still asserted.
- The block never drives EBUS except in WR, WR_HOLD and CONI cycles.
- CROBAR mid-sequence: immediately returns to IDLE with all outputs 0; any pending response is lost.

Test Plan:
- Reset: assert CROBAR → all outputs 0, host_cmd_ready=1 after release.
- Diag write: op1, func=7'o071, data=36'o123456701234 → one cycle with strobe=1, two cycles driving=1 with that data, then idle.
- Diag read: op0, func=7'o005, ebus_data_in=36'o777000111222, SETTLE=2 → host_rsp_valid 3 cycles after accept; rsp_data = input; driving stays 0.
- Status: op2 mask 36'o000000000017, then op3 mask 36'o000000000005 → status=36'o12. CONI with cs=DEV_CS → ack, data_out=36'o12 for one cycle.
- CONO: cs=DEV_CS, ebus_data_in=36'o400000000001 → status equals that value, ack for one cycle. Same request with cs=7'b0000001 → no ack, status unchanged.
- Collision: ebox_req (CONI) and host_cmd_valid in the same IDLE cycle → EBOX acked first, ready=0 that cycle; host accepted the next cycle.
